// File: rtl/core_pkg.sv
// Shared ISA constants, FSM/ALU enums and instruction field helpers for the
// multi-cycle 16-bit-ISA core.
package core_pkg;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b1011;
  localparam logic [3:0] OP_SW   = 4'b1111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b0010;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_EOR = 3'b001;
  localparam logic [2:0] F_SUB = 3'b010;
  localparam logic [2:0] F_BIC = 3'b011;
  localparam logic [2:0] F_AND = 3'b100;
  localparam logic [2:0] F_OR  = 3'b101;
  localparam logic [2:0] F_NOP = 3'b110;
  localparam logic [2:0] F_RSB = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_EOR, ALU_BIC, ALU_RSB
  } alu_op_e;

  function automatic logic [3:0] f_opcode(input logic [15:0] ir);
    return ir[15:12];
  endfunction

  function automatic logic [2:0] f_rs(input logic [15:0] ir);
    return ir[11:9];
  endfunction

  function automatic logic [2:0] f_rt(input logic [15:0] ir);
    return ir[8:6];
  endfunction

  function automatic logic [2:0] f_rd(input logic [15:0] ir);
    return ir[5:3];
  endfunction

  function automatic logic [2:0] f_funct(input logic [15:0] ir);
    return ir[2:0];
  endfunction

  // Signed so that a size cast at the use site sign-extends to any width.
  function automatic logic signed [5:0] f_imm(input logic [15:0] ir);
    return $signed(ir[5:0]);
  endfunction

  function automatic logic [11:0] f_target(input logic [15:0] ir);
    return ir[11:0];
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

  function automatic alu_op_e funct_to_alu(input logic [2:0] funct);
    case (funct)
      F_ADD:   return ALU_ADD;
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_EOR:   return ALU_EOR;
      F_BIC:   return ALU_BIC;
      F_RSB:   return ALU_RSB;
      F_NOP:   return ALU_ADD;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU: all arithmetic wraps modulo 2^DATA_W; eq feeds BEQ.
module core_alu
  import core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        alu_op,
  output logic [DATA_W-1:0] y,
  output logic              eq
);

  always_comb begin
    y = '0;
    case (alu_op_e'(alu_op))
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_EOR: y = a ^ b;
      ALU_BIC: y = a & ~b;
      ALU_RSB: y = b - a;
      default: y = a + b;
    endcase
  end

  assign eq = (a == b);

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle core for the 16-bit ISA: FETCH/DECODE/EXEC/MEM/WB/HALT FSM,
// parametrised datapath, stallable memory ports and a retire counter.
module multicycle_core
  import core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              halted,
  output logic [CNT_W-1:0]  retired,
  output logic [15:0]       out
);

  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  // Memory handshake: req rises when the FSM enters FETCH/MEM and stays high
  // with address/we/wdata frozen until the cycle ack is seen (ack may come in
  // the same cycle as req); ack while req=0 is ignored; one transaction max.

  state_e              state, state_nxt;
  logic [15:0]         ir;
  logic [ADDR_W-1:0]   pc, addr_q;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   a_q, b_q, imm_q, res_q;
  logic [DATA_W-1:0]   a_rd, b_rd, alu_b, alu_y;
  logic                alu_eq;
  logic [2:0]          alu_op;
  logic [3:0]          opc;
  logic [RIDX_W-1:0]   rs_i, rt_i, wb_idx;
  logic                wb_en, retire;
  logic [15:0]         res16;

  assign opc    = f_opcode(ir);
  assign rs_i   = RIDX_W'(f_rs(ir));
  assign rt_i   = RIDX_W'(f_rt(ir));
  assign wb_idx = (opc == OP_R) ? RIDX_W'(f_rd(ir)) : rt_i;
  assign wb_en  = !((opc == OP_R) && (f_funct(ir) == F_NOP));

  assign a_rd   = (rs_i == '0) ? '0 : regs[rs_i];
  assign b_rd   = (rt_i == '0) ? '0 : regs[rt_i];

  // BEQ compares A with B through the ALU's eq, so only ADDI takes imm.
  assign alu_b  = (opc == OP_ADDI) ? imm_q : b_q;
  assign alu_op = (opc == OP_R) ? 3'(funct_to_alu(f_funct(ir))) : 3'(ALU_ADD);

  core_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (alu_b),
    .alu_op (alu_op),
    .y      (alu_y),
    .eq     (alu_eq)
  );

  generate
    if (DATA_W >= 16) begin : g_out_trunc
      assign res16 = res_q[15:0];
    end else begin : g_out_zext
      assign res16 = {{(16 - DATA_W){1'b0}}, res_q};
    end
  endgenerate

  assign imem_addr  = pc;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = b_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    halted    = 1'b0;
    retire    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = op_legal(opc) ? S_EXEC : S_HALT;
      S_EXEC: begin
        if ((opc == OP_LW) || (opc == OP_SW)) begin
          state_nxt = S_MEM;
        end else if ((opc == OP_BEQ) || (opc == OP_J)) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opc == OP_SW);
        if (dmem_ack) begin
          state_nxt = (opc == OP_LW) ? S_WB : S_FETCH;
          retire    = (opc == OP_SW);
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      addr_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      retired <= '0;
      out     <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (retire) retired <= retired + CNT_W'(1);
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ir <= imem_rdata;
            pc <= pc + ADDR_W'(1);
          end
        end
        S_DECODE: begin
          a_q   <= a_rd;
          b_q   <= b_rd;
          imm_q <= DATA_W'(f_imm(ir));
        end
        S_EXEC: begin
          res_q  <= alu_y;
          addr_q <= ADDR_W'(a_q) + ADDR_W'(f_imm(ir));
          // pc already points past the branch, so the offset is from PC+1.
          if ((opc == OP_BEQ) && alu_eq) pc <= pc + ADDR_W'(f_imm(ir));
          if (opc == OP_J) pc <= ADDR_W'(f_target(ir));
        end
        S_MEM: begin
          if (dmem_ack && (opc == OP_LW)) res_q <= dmem_rdata;
        end
        S_WB: begin
          if (wb_en) begin
            if (wb_idx != '0) regs[wb_idx] <= res_q;
            out <= res16;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: bench-modelled imem/dmem, scoreboard of
// expected write-back values popped on every retire, plus a 16-bit build.
module tb_multicycle_core;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int NREGS  = 8;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic              imem_req, imem_ack;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic              dmem_req, dmem_we, dmem_ack;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata, dmem_rdata;
  logic              halted;
  logic [CNT_W-1:0]  retired;
  logic [15:0]       out;

  multicycle_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .halted(halted), .retired(retired), .out(out)
  );

  logic        imem16_req, imem16_ack;
  logic [7:0]  imem16_addr;
  logic [15:0] imem16_rdata;
  logic        dmem16_req, dmem16_we;
  logic [7:0]  dmem16_addr;
  logic [15:0] dmem16_wdata;
  logic [15:0] dmem16_rdata = 16'h0;
  logic        dmem16_ack = 1'b0;
  logic        halted16;
  logic [15:0] retired16, out16;

  multicycle_core #(.DATA_W(16), .ADDR_W(8), .NREGS(4), .CNT_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem16_req), .imem_addr(imem16_addr), .imem_rdata(imem16_rdata), .imem_ack(imem16_ack),
    .dmem_req(dmem16_req), .dmem_we(dmem16_we), .dmem_addr(dmem16_addr), .dmem_wdata(dmem16_wdata),
    .dmem_rdata(dmem16_rdata), .dmem_ack(dmem16_ack),
    .halted(halted16), .retired(retired16), .out(out16)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_out = 16'h0;
  int exp_ret = 0;
  int last_fetch = 0;
  logic [CNT_W-1:0] last_ret = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every retire must be a +1 step and must match the oldest expectation.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      last_ret = retired;
    end else if (retired !== last_ret) begin
      check("retire_step", 32'(retired), 32'(last_ret) + 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL retire_unexpected: observed retired=%0d expected no retire", retired);
      end else begin
        check("wb_out", 32'(out), 32'(exp_q.pop_front()));
      end
      last_ret = retired;
    end
  end

  // ---------------- driver tasks (all run at negedge) ----------------
  task automatic serve_fetch(input string tag, input logic [15:0] instr,
                             input logic [ADDR_W-1:0] exp_addr, input int exp_lat,
                             input logic [15:0] out_after);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 32'(imem_req), 32'd1);
    check({tag, "_pc"}, 32'(imem_addr), 32'(exp_addr));
    if (exp_lat != 0) check({tag, "_latency"}, cyc - last_fetch, exp_lat);
    last_fetch = cyc;
    imem_rdata = instr;
    imem_ack   = 1'b1;
    exp_q.push_back(out_after);
    exp_out = out_after;
    exp_ret++;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic serve_mem(input string tag, input logic exp_we, input logic [ADDR_W-1:0] exp_addr,
                           input logic [DATA_W-1:0] exp_wdata, input int delay,
                           input logic [DATA_W-1:0] rdata);
    int n = 0;
    while (dmem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, 32'(dmem_req), 32'd1);
    check({tag, "_we"}, 32'(dmem_we), 32'(exp_we));
    check({tag, "_addr"}, 32'(dmem_addr), 32'(exp_addr));
    check({tag, "_wdata"}, 32'(dmem_wdata), 32'(exp_wdata));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, {dmem_req, dmem_we, 22'd0, dmem_addr}, {1'b1, exp_we, 22'd0, exp_addr});
    end
    dmem_rdata = rdata;
    dmem_ack   = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_imem_req"}, 32'(imem_req), 32'd1);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_retired"}, 32'(retired), 32'd0);
    check({tag, "_out"}, 32'(out), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_dmem"}, {dmem_req, dmem_we}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int seen;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    imem16_ack = 1'b0;
    imem16_rdata = 16'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("reset");

    serve_fetch("addi_r1", 16'h4045, 8'd0, 0, 16'h0005);
    serve_fetch("addi_r2", 16'h4083, 8'd1, 4, 16'h0003);
    serve_fetch("add",  16'h0298, 8'd2, 4, 16'h0008);
    serve_fetch("sub",  16'h029A, 8'd3, 4, 16'h0002);
    serve_fetch("and",  16'h029C, 8'd4, 4, 16'h0001);
    serve_fetch("or",   16'h029D, 8'd5, 4, 16'h0007);
    serve_fetch("eor",  16'h0299, 8'd6, 4, 16'h0006);
    serve_fetch("bic",  16'h029B, 8'd7, 4, 16'h0004);
    serve_fetch("rsb",  16'h029F, 8'd8, 4, 16'h00FE);
    serve_fetch("nop",  16'h029E, 8'd9, 4, 16'h00FE);
    serve_fetch("sw",   16'hF040, 8'd10, 4, exp_out);
    serve_mem("sw_mem", 1'b1, 8'd0, 8'd5, 3, 8'h00);
    serve_fetch("lw",   16'hB100, 8'd11, 0, 16'h0005);
    serve_mem("lw_mem", 1'b0, 8'd0, 8'd0, 3, 8'h05);
    serve_fetch("j4",   16'h2004, 8'd12, 0, exp_out);
    serve_fetch("beq_taken", 16'h827E, 8'd4, 3, exp_out);
    serve_fetch("j4b",  16'h2004, 8'd3, 3, exp_out);
    serve_fetch("beq_not", 16'h82BE, 8'd4, 3, exp_out);
    serve_fetch("j_a0", 16'h20A0, 8'd5, 3, exp_out);
    serve_fetch("addi_neg", 16'h437F, 8'hA0, 3, 16'h0004);
    serve_fetch("addi_r0",  16'h4202, 8'hA1, 4, 16'h0007);
    serve_fetch("add_r0",   16'h0070, 8'hA2, 4, 16'h0005);

    // Illegal opcode: pop our own expectation, it never retires.
    serve_fetch("illegal", 16'h1000, 8'hA3, 4, exp_out);
    void'(exp_q.pop_back());
    exp_ret--;
    @(negedge clk);
    check("halted_within_2", 32'(halted), 32'd1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b0 || dmem_req !== 1'b0) seen++;
    end
    check("halt_no_requests", seen, 0);
    check("halt_retired", 32'(retired), exp_ret);
    check("scoreboard_drained", exp_q.size(), 0);

    // Reset out of HALT, then abort a stalled load with reset.
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check_reset_state("reset_from_halt");
    serve_fetch("lw_abort", 16'hB100, 8'd0, 0, 16'h0005);
    seen = 0;
    while (dmem_req !== 1'b1 && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    check("abort_dmem_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_drops_dmem_req", 32'(dmem_req), 32'd0);
    dmem_rdata = 8'h77;
    dmem_ack   = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    rst_n    = 1'b1;
    exp_q.delete();
    check_reset_state("reset_mid_mem");
    serve_fetch("regs_cleared", 16'h4280, 8'd0, 0, 16'h0000);
    serve_fetch("after_rst_addi", 16'h4045, 8'd1, 4, 16'h0005);
    repeat (4) @(negedge clk);
    check("after_rst_retired", 32'(retired), 32'd2);
    check("scoreboard_drained2", exp_q.size(), 0);

    // DATA_W=16, NREGS=4 build.
    seen = 0;
    while (imem16_req !== 1'b1 && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    check("w16_req", 32'(imem16_req), 32'd1);
    imem16_rdata = 16'h407F;
    imem16_ack   = 1'b1;
    @(negedge clk);
    imem16_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("w16_addi_neg1", 32'(out16), 32'h0000FFFF);
    check("w16_next_pc", {imem16_req, 23'd0, imem16_addr}, {1'b1, 23'd0, 8'd1});
    imem16_rdata = 16'h005A;
    imem16_ack   = 1'b1;
    @(negedge clk);
    imem16_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("w16_sub", 32'(out16), 32'h00000001);
    check("w16_retired", 32'(retired16), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
